// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the sequential ALU: opcode encodings, FSM state
//   encoding, flag bit positions inside the packed NZCV register, and a
//   helper that classifies shift/rotate opcodes.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  // Opcode encodings
  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_XOR = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_RSB = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_ADC = 4'd5;
  localparam logic [3:0] OP_SBC = 4'd6;
  localparam logic [3:0] OP_RSC = 4'd7;
  localparam logic [3:0] OP_LSL = 4'd8;
  localparam logic [3:0] OP_LSR = 4'd9;
  localparam logic [3:0] OP_ASR = 4'd10;
  localparam logic [3:0] OP_ROR = 4'd11;
  localparam logic [3:0] OP_ORR = 4'd12;
  localparam logic [3:0] OP_MOV = 4'd13;
  localparam logic [3:0] OP_BIC = 4'd14;
  localparam logic [3:0] OP_MVN = 4'd15;

  // FSM state encoding
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit positions of the flags inside the packed {N,Z,C,V} register
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  // Ops 8..11 are the shift/rotate group
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_core.sv
// ---------------------------------------------------------------------------
// alu_seq_core
//   Combinational single-cycle datapath for the logical and arithmetic
//   opcodes (0..7, 12..15). Arithmetic is performed in W+1 bits so the
//   carry is bit W of the sum. Shift opcodes produce zero here; the parent
//   handles them.
//   Ports:
//     a_i, b_i  operands A and B
//     op_i      opcode
//     cin_i     stored C flag, used by ADC/SBC/RSC
//     res_o     W-bit result
//     c_o, v_o  carry and overflow (both 0 for logical ops)
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_seq_core
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [3:0]   op_i,
  input  logic         cin_i,
  output logic [W-1:0] res_o,
  output logic         c_o,
  output logic         v_o
);

  logic [W-1:0] add_x;
  logic [W-1:0] add_y;
  logic         add_ci;
  logic [W:0]   sum;
  logic         is_arith;

  // Every arithmetic op reduces to x + y + ci with suitable operand selection
  always_comb begin
    add_x    = a_i;
    add_y    = b_i;
    add_ci   = 1'b0;
    is_arith = 1'b1;
    case (op_i)
      OP_SUB:  begin add_x = a_i; add_y = ~b_i; add_ci = 1'b1;  end
      OP_RSB:  begin add_x = b_i; add_y = ~a_i; add_ci = 1'b1;  end
      OP_ADD:  begin add_x = a_i; add_y = b_i;  add_ci = 1'b0;  end
      OP_ADC:  begin add_x = a_i; add_y = b_i;  add_ci = cin_i; end
      OP_SBC:  begin add_x = a_i; add_y = ~b_i; add_ci = cin_i; end
      OP_RSC:  begin add_x = b_i; add_y = ~a_i; add_ci = cin_i; end
      default: is_arith = 1'b0;
    endcase
  end

  assign sum = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_ci};

  always_comb begin
    res_o = '0;
    c_o   = 1'b0;
    v_o   = 1'b0;
    if (is_arith) begin
      res_o = sum[W-1:0];
      c_o   = sum[W];
      // Overflow: adder inputs agree in sign but the result does not
      v_o   = (add_x[W-1] == add_y[W-1]) && (sum[W-1] != add_x[W-1]);
    end else begin
      case (op_i)
        OP_AND:  res_o = a_i & b_i;
        OP_XOR:  res_o = a_i ^ b_i;
        OP_ORR:  res_o = a_i | b_i;
        OP_MOV:  res_o = b_i;
        OP_BIC:  res_o = a_i & ~b_i;
        OP_MVN:  res_o = ~b_i;
        default: res_o = '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
//   Sequential ALU with registered result and NZCV flags, start/busy/done
//   handshake, and iterative one-bit-per-cycle shifts/rotates.
//   Build option: ALU_SHIFT_EN. When undefined, the shift state, counter and
//   shift register are absent; ops 8..11 complete at once flagged illegal,
//   leaving result and flags untouched, and out_busy is tied low.
//   Ports:
//     clk, reset           clock, synchronous active-high reset
//     inp_start            request, accepted while not busy
//     inp_src0, inp_src1   operands A and B (B[SHW-1:0] = shift amount)
//     operation_select     opcode
//     inp_set_flags        1 = update flags for this request
//     out_busy             high while a shift iterates
//     out_done             one-cycle completion pulse
//     out_alu              registered result
//     carry_out_flag, overflow_flag, negative_flag, zero_flag   stored C,V,N,Z
//     out_illegal          pulses with out_done for unsupported opcodes
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inp_start,
  input  logic [W-1:0] inp_src0,
  input  logic [W-1:0] inp_src1,
  input  logic [3:0]   operation_select,
  input  logic         inp_set_flags,
  output logic         out_busy,
  output logic         out_done,
  output logic [W-1:0] out_alu,
  output logic         carry_out_flag,
  output logic         overflow_flag,
  output logic         negative_flag,
  output logic         zero_flag,
  output logic         out_illegal
);

  localparam int SHW = $clog2(W);

  logic [W-1:0] alu_q,     alu_d;
  logic [3:0]   flags_q,   flags_d;
  logic         done_q,    done_d;
  logic         illegal_q, illegal_d;
  logic         idle;

  logic [W-1:0] core_res;
  logic         core_c;
  logic         core_v;

  alu_seq_core #(.W(W)) u_core (
    .a_i   (inp_src0),
    .b_i   (inp_src1),
    .op_i  (operation_select),
    .cin_i (flags_q[FLAG_C]),
    .res_o (core_res),
    .c_o   (core_c),
    .v_o   (core_v)
  );

`ifdef ALU_SHIFT_EN
  state_e         state_q, state_d;
  logic [SHW-1:0] cnt_q,   cnt_d;
  logic [W-1:0]   sh_q,    sh_d;
  logic [1:0]     sop_q,   sop_d;
  logic           setf_q,  setf_d;
  logic [W-1:0]   step;
  logic           step_c;

  assign idle     = (state_q == ST_IDLE);
  assign out_busy = (state_q == ST_SHIFT);

  // One-bit step of the latched shift; low opcode bits select the kind
  always_comb begin
    step   = sh_q;
    step_c = 1'b0;
    case (sop_q)
      2'b00: begin step = {sh_q[W-2:0], 1'b0};      step_c = sh_q[W-1]; end
      2'b01: begin step = {1'b0, sh_q[W-1:1]};      step_c = sh_q[0];   end
      2'b10: begin step = {sh_q[W-1], sh_q[W-1:1]}; step_c = sh_q[0];   end
      default: begin step = {sh_q[0], sh_q[W-1:1]}; step_c = sh_q[0];   end
    endcase
  end
`else
  assign idle     = 1'b1;
  assign out_busy = 1'b0;
`endif

  always_comb begin
    alu_d     = alu_q;
    flags_d   = flags_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
`ifdef ALU_SHIFT_EN
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    sop_d     = sop_q;
    setf_d    = setf_q;
`endif
    if (idle && inp_start) begin
      if (is_shift_op(operation_select)) begin
`ifdef ALU_SHIFT_EN
        if (inp_src1[SHW-1:0] == '0) begin
          // Zero shift: pass A through, C and V keep their values
          alu_d  = inp_src0;
          done_d = 1'b1;
          if (inp_set_flags) begin
            flags_d[FLAG_N] = inp_src0[W-1];
            flags_d[FLAG_Z] = (inp_src0 == '0);
          end
        end else begin
          state_d = ST_SHIFT;
          cnt_d   = inp_src1[SHW-1:0];
          sh_d    = inp_src0;
          sop_d   = operation_select[1:0];
          setf_d  = inp_set_flags;
        end
`else
        done_d    = 1'b1;
        illegal_d = 1'b1;
`endif
      end else begin
        alu_d  = core_res;
        done_d = 1'b1;
        if (inp_set_flags) begin
          flags_d[FLAG_N] = core_res[W-1];
          flags_d[FLAG_Z] = (core_res == '0);
          flags_d[FLAG_C] = core_c;
          flags_d[FLAG_V] = core_v;
        end
      end
    end
`ifdef ALU_SHIFT_EN
    else if (state_q == ST_SHIFT) begin
      sh_d = step;
      if (cnt_q == SHW'(1)) begin
        state_d = ST_IDLE;
        alu_d   = step;
        done_d  = 1'b1;
        if (setf_q) begin
          flags_d[FLAG_N] = step[W-1];
          flags_d[FLAG_Z] = (step == '0);
          flags_d[FLAG_C] = step_c;
        end
      end else begin
        cnt_d = cnt_q - SHW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_q     <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_SHIFT_EN
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      sop_q     <= '0;
      setf_q    <= 1'b0;
`endif
    end else begin
      alu_q     <= alu_d;
      flags_q   <= flags_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
`ifdef ALU_SHIFT_EN
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      sop_q     <= sop_d;
      setf_q    <= setf_d;
`endif
    end
  end

  assign out_alu        = alu_q;
  assign out_done       = done_q;
  assign out_illegal    = illegal_q;
  assign negative_flag  = flags_q[FLAG_N];
  assign zero_flag      = flags_q[FLAG_Z];
  assign carry_out_flag = flags_q[FLAG_C];
  assign overflow_flag  = flags_q[FLAG_V];

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
//   Directed self-checking bench for alu_seq at W=8. Flags are compared as
//   a packed {N,Z,C,V} nibble. Shift scenarios are exercised when
//   ALU_SHIFT_EN is defined; otherwise the illegal-opcode path is checked.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         inp_start;
  logic [W-1:0] inp_src0;
  logic [W-1:0] inp_src1;
  logic [3:0]   operation_select;
  logic         inp_set_flags;
  logic         out_busy;
  logic         out_done;
  logic [W-1:0] out_alu;
  logic         carry_out_flag;
  logic         overflow_flag;
  logic         negative_flag;
  logic         zero_flag;
  logic         out_illegal;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  alu_seq #(.W(W)) dut (
    .clk              (clk),
    .reset            (reset),
    .inp_start        (inp_start),
    .inp_src0         (inp_src0),
    .inp_src1         (inp_src1),
    .operation_select (operation_select),
    .inp_set_flags    (inp_set_flags),
    .out_busy         (out_busy),
    .out_done         (out_done),
    .out_alu          (out_alu),
    .carry_out_flag   (carry_out_flag),
    .overflow_flag    (overflow_flag),
    .negative_flag    (negative_flag),
    .zero_flag        (zero_flag),
    .out_illegal      (out_illegal)
  );

  function automatic logic [3:0] nzcv();
    return {negative_flag, zero_flag, carry_out_flag, overflow_flag};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Drive a request for exactly one edge; returns #1 after that edge
  task automatic issue(input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic sf);
    @(negedge clk);
    operation_select = op;
    inp_src0         = a;
    inp_src1         = b;
    inp_set_flags    = sf;
    inp_start        = 1'b1;
    @(posedge clk);
    #1;
    inp_start = 1'b0;
  endtask

  // Single-cycle op: result, flags and done visible right after the edge
  task automatic op1(input string tag, input logic [3:0] op, input logic [7:0] a,
                     input logic [7:0] b, input logic sf,
                     input logic [7:0] exp_res, input logic [3:0] exp_f);
    issue(op, a, b, sf);
    chk({tag, "_res"},  {24'd0, out_alu}, {24'd0, exp_res});
    chk({tag, "_nzcv"}, {28'd0, nzcv()}, {28'd0, exp_f});
    chk({tag, "_done"}, {31'd0, out_done}, 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset            = 1'b1;
    inp_start        = 1'b0;
    inp_src0         = '0;
    inp_src1         = '0;
    operation_select = '0;
    inp_set_flags    = 1'b0;
    tick();
    tick();
    chk("rst_res",  {24'd0, out_alu}, 32'd0);
    chk("rst_nzcv", {28'd0, nzcv()}, 32'd0);
    chk("rst_busy", {31'd0, out_busy}, 32'd0);
    chk("rst_done", {31'd0, out_done}, 32'd0);
    chk("rst_ill",  {31'd0, out_illegal}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Arithmetic
    op1("add_ovf", 4'd4, 8'h7F, 8'h01, 1'b1, 8'h80, 4'b1001);
    chk("add_busy", {31'd0, out_busy}, 32'd0);
    tick();
    chk("add_done_drop", {31'd0, out_done}, 32'd0);
    op1("sub_eq",  4'd2, 8'h05, 8'h05, 1'b1, 8'h00, 4'b0110);
    op1("add_ff",  4'd4, 8'hFF, 8'h00, 1'b1, 8'hFF, 4'b1000);
    op1("sbc_c0",  4'd6, 8'h05, 8'h05, 1'b1, 8'hFF, 4'b1000);
    op1("sub_c1",  4'd2, 8'h05, 8'h03, 1'b1, 8'h02, 4'b0010);
    op1("adc_c1",  4'd5, 8'h10, 8'h20, 1'b1, 8'h31, 4'b0000);
    op1("rsb",     4'd3, 8'h03, 8'h10, 1'b1, 8'h0D, 4'b0010);
    op1("rsc_c1",  4'd7, 8'h10, 8'h03, 1'b1, 8'hF3, 4'b1000);
    op1("sub_neg", 4'd2, 8'h80, 8'h01, 1'b1, 8'h7F, 4'b0011);
    // Logical; set_flags=0 must preserve flags
    op1("mvn_nf",  4'd15, 8'h00, 8'h00, 1'b0, 8'hFF, 4'b0011);
    op1("and",     4'd0, 8'hF0, 8'h3C, 1'b1, 8'h30, 4'b0000);
    op1("bic",     4'd14, 8'hFF, 8'h0F, 1'b1, 8'hF0, 4'b1000);
    op1("xor",     4'd1, 8'h55, 8'h55, 1'b1, 8'h00, 4'b0100);
    op1("orr",     4'd12, 8'h0F, 8'hF0, 1'b1, 8'hFF, 4'b1000);
    op1("mov",     4'd13, 8'h00, 8'h42, 1'b1, 8'h42, 4'b0000);

`ifdef ALU_SHIFT_EN
    op1("add_v", 4'd4, 8'h7F, 8'h01, 1'b1, 8'h80, 4'b1001);
    // LSR 0x80 by 7, with an ignored start mid-shift
    issue(4'd9, 8'h80, 8'd7, 1'b1);
    chk("lsr_busy0", {31'd0, out_busy}, 32'd1);
    chk("lsr_done0", {31'd0, out_done}, 32'd0);
    for (int i = 1; i < 7; i++) begin
      if (i == 3) begin
        issue(4'd4, 8'h11, 8'h22, 1'b1);
      end else begin
        tick();
      end
      chk("lsr_busy", {31'd0, out_busy}, 32'd1);
      chk("lsr_nodone", {31'd0, out_done}, 32'd0);
    end
    tick();
    chk("lsr_res",  {24'd0, out_alu}, 32'h01);
    chk("lsr_nzcv", {28'd0, nzcv()}, 32'b0001);
    chk("lsr_done", {31'd0, out_done}, 32'd1);
    chk("lsr_idle", {31'd0, out_busy}, 32'd0);
    tick();
    chk("lsr_pulse", {31'd0, out_done}, 32'd0);
    chk("lsr_hold",  {24'd0, out_alu}, 32'h01);
    // ROR by 1, latency 1
    issue(4'd11, 8'h81, 8'd1, 1'b1);
    chk("ror_busy", {31'd0, out_busy}, 32'd1);
    tick();
    chk("ror_res",  {24'd0, out_alu}, 32'hC0);
    chk("ror_nzcv", {28'd0, nzcv()}, 32'b1011);
    chk("ror_done", {31'd0, out_done}, 32'd1);
    issue(4'd11, 8'h02, 8'd1, 1'b0);
    tick();
    chk("ror_nf_res",  {24'd0, out_alu}, 32'h01);
    chk("ror_nf_nzcv", {28'd0, nzcv()}, 32'b1011);
    // Zero shift amount completes at once, C and V kept
    op1("lsl0", 4'd8, 8'h00, 8'h00, 1'b1, 8'h00, 4'b0111);
    chk("lsl0_busy", {31'd0, out_busy}, 32'd0);
    // Reset during ASR by 5
    issue(4'd10, 8'h80, 8'd5, 1'b1);
    tick();
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("asr_rst_res",  {24'd0, out_alu}, 32'd0);
    chk("asr_rst_nzcv", {28'd0, nzcv()}, 32'd0);
    chk("asr_rst_busy", {31'd0, out_busy}, 32'd0);
    chk("asr_rst_done", {31'd0, out_done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("asr_rst_nodone", {31'd0, out_done}, 32'd0);
    end
`else
    // Shifts unsupported: flagged illegal, state untouched
    issue(4'd9, 8'hAA, 8'h03, 1'b1);
    chk("ill_done", {31'd0, out_done}, 32'd1);
    chk("ill_flag", {31'd0, out_illegal}, 32'd1);
    chk("ill_res",  {24'd0, out_alu}, 32'h42);
    chk("ill_nzcv", {28'd0, nzcv()}, 32'b0000);
    chk("ill_busy", {31'd0, out_busy}, 32'd0);
    tick();
    chk("ill_pulse", {31'd0, out_illegal}, 32'd0);
    chk("ill_done_drop", {31'd0, out_done}, 32'd0);
    op1("legal_after", 4'd4, 8'h01, 8'h01, 1'b1, 8'h02, 4'b0000);
    chk("legal_noill", {31'd0, out_illegal}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
